// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner and instruction fetch front end.
// Issues word reads to instruction memory under a credit limit.
// Tags each request with its PC, buffers returned words in order, and
// hands {pc, inst} to the decoder over valid/ready.
// Redirects from execute flush the buffer. Responses already in flight
// are then dropped while the FSM sits in DRAIN.
// Optional feature: define JMP_PREDECODE_EN to let JMP/CALL words
// self-redirect fetch as soon as they return from memory.

// Small in-order FIFO, used both as the PC tag queue and the output buffer.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign dout = mem[rd_ptr];

  // Pointer/count bookkeeping. Storage is cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [CW-1:0]  drop_cnt;
  logic [CW-1:0]  in_flight;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  remaining;
  logic [31:0]    tag_pc;
  logic [63:0]    head;
  logic           credit;
  logic           fire;
  logic           rsp_enq;
  logic           deq;
  logic           self_redir;
  logic [31:0]    jmp_target;

`ifdef JMP_PREDECODE_EN
  // A JMP/CALL word returning in FETCH steers fetch to its target right away.
  assign self_redir = imem_rsp_valid && (state == FETCH) &&
                      ((imem_rsp_data[31:26] == 6'b001100) ||
                       (imem_rsp_data[31:26] == 6'b001101));
  assign jmp_target = {tag_pc[31:26], imem_rsp_data[25:0]};
`else
  assign self_redir = 1'b0;
  assign jmp_target = '0;
`endif

  // Requests stop once outstanding words could overfill the buffer, and in any redirect cycle.
  assign credit = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = (state == FETCH) && credit && !redirect_valid && !self_redir;
  assign imem_addr      = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  // An external redirect wins over a same-cycle response; that word is dropped.
  assign rsp_enq   = imem_rsp_valid && (state == FETCH) && !redirect_valid;
  assign out_valid = (fifo_count != '0);
  assign deq       = out_valid && out_ready;
  assign out_pc    = head[63:32];
  assign out_inst  = head[31:0];

  // Responses still owed once this cycle's response (if any) has been retired.
  assign remaining = in_flight - CW'(imem_rsp_valid);

  ifu_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (fire),
    .din   (pc),
    .pop   (imem_rsp_valid),
    .dout  (tag_pc),
    .count (in_flight)
  );

  ifu_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_out_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (rsp_enq),
    .din   ({tag_pc, imem_rsp_data}),
    .pop   (deq),
    .dout  (head),
    .count (fifo_count)
  );

  // FETCH/DRAIN control: PC advance, redirect capture and wrong-path drop counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid || self_redir) begin
            pc       <= redirect_valid ? redirect_pc : jmp_target;
            drop_cnt <= remaining;
            state    <= (remaining != '0) ? DRAIN : FETCH;
          end else if (fire) begin
            pc <= pc + 32'd1;
          end
        end
        DRAIN: begin
          if (redirect_valid) pc <= redirect_pc;
          if (imem_rsp_valid) begin
            drop_cnt <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a vector table covers streaming and
// back-pressure; hand sequences cover redirect, drain, wrap, JMP and reset.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int n_cmp = 0;
  int n_err = 0;

  logic        stall = 1'b0;
  logic        plant = 1'b0;
  logic [31:0] pend[$];
  logic [63:0] got[$];

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    if (plant && a == 32'd5) return 32'h3000_0040;
    return {6'b000101, a[25:0] ^ 26'h15A5A5A};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then play memory and clear redirect.
  task automatic tick();
    logic f, o;
    logic [31:0] a;
    logic [63:0] h;
    #1;
    f = imem_req_valid && imem_req_ready && !rst;
    a = imem_addr;
    o = out_valid && out_ready && !rst;
    h = {out_pc, out_inst};
    @(posedge clk);
    if (f) pend.push_back(a);
    if (o) got.push_back(h);
    #1;
    if (!stall && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = w(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    plant = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pend.delete();
    got.delete();
    imem_rsp_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] opc;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] addr,
                              input logic ov, input logic [31:0] opc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.addr = addr; v.ov = ov; v.opc = opc;
    return v;
  endfunction

  initial begin
    // Stream, then 10 cycles of decoder back-pressure, then release.
    tbl[0]  = mk(1'b1, 1'b1, 32'd1, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 1'b1, 32'd2, 1'b1, 32'd0);
    tbl[2]  = mk(1'b1, 1'b1, 32'd3, 1'b1, 32'd1);
    tbl[3]  = mk(1'b1, 1'b1, 32'd4, 1'b1, 32'd2);
    tbl[4]  = mk(1'b0, 1'b1, 32'd5, 1'b1, 32'd2);
    for (int i = 5; i <= 13; i++) tbl[i] = mk(1'b0, 1'b0, 32'd6, 1'b1, 32'd2);
    tbl[14] = mk(1'b1, 1'b1, 32'd6, 1'b1, 32'd3);
    tbl[15] = mk(1'b1, 1'b1, 32'd7, 1'b1, 32'd4);
    tbl[16] = mk(1'b1, 1'b1, 32'd8, 1'b1, 32'd5);
    tbl[17] = mk(1'b1, 1'b1, 32'd9, 1'b1, 32'd6);
    tbl[18] = mk(1'b1, 1'b1, 32'd10, 1'b1, 32'd7);

    reset_dut();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);

    for (int i = 0; i < 19; i++) begin
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].rv});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].opc);
        chk($sformatf("vec%0d_out_inst", i), out_inst, w(tbl[i].opc));
      end
    end
    chk("stream_count", got.size(), 32'd7);
    for (int k = 0; k < 7 && k < got.size(); k++) begin
      chk($sformatf("stream%0d_pc", k), got[k][63:32], k);
      chk($sformatf("stream%0d_inst", k), got[k][31:0], w(k));
    end

    // Two requests in flight, redirect to 0x100, both returns dropped.
    reset_dut();
    stall = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("redir_cycle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("redir_drain_req", {31'd0, imem_req_valid}, 32'd0);
    chk("redir_flush_ov", {31'd0, out_valid}, 32'd0);
    stall = 1'b0;
    tick();
    chk("drain_wait0", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("drain_after_drop1", {31'd0, imem_req_valid}, 32'd0);
    chk("drain_no_out", {31'd0, out_valid}, 32'd0);
    tick();
    chk("drain_done_req", {31'd0, imem_req_valid}, 32'd1);
    chk("drain_done_addr", imem_addr, 32'h100);
    tick();
    chk("redir_first_fetch_ov", {31'd0, out_valid}, 32'd0);
    tick();
    chk("redir_out_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_out_pc", out_pc, 32'h100);
    chk("redir_out_inst", out_inst, w(32'h100));

    // Redirect with response and out_ready in the same cycle.
    reset_dut();
    tick();
    tick();
    chk("same_pre_pc", out_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    chk("same_ov", {31'd0, out_valid}, 32'd0);
    chk("same_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("same_addr", imem_addr, 32'h200);
    tick();
    tick();
    chk("same_next_pc", out_pc, 32'h200);

    // PC wrap at the top of the address space.
    reset_dut();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    chk("wrap_ov", {31'd0, out_valid}, 32'd0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    tick();
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFF);

    // JMP word at PC 5.
    reset_dut();
    plant = 1'b1;
    for (int i = 0; i < 6; i++) tick();
`ifdef JMP_PREDECODE_EN
    chk("jmp_gate_req", {31'd0, imem_req_valid}, 32'd0);
`else
    chk("jmp_gate_req", {31'd0, imem_req_valid}, 32'd1);
`endif
    tick();
    chk("jmp_out_pc", out_pc, 32'd5);
    chk("jmp_out_inst", out_inst, 32'h3000_0040);
`ifdef JMP_PREDECODE_EN
    chk("jmp_next_addr", imem_addr, 32'h40);
`else
    chk("jmp_next_addr", imem_addr, 32'd7);
`endif

    // Reset in the middle of DRAIN.
    reset_dut();
    stall = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    chk("pre_rst_drain", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend.delete();
    stall = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mid_rst_fetch", imem_addr, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
